wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage of the 5-stage pipelined CPU, directly downstream of the memory stage. It owns the MEM/WB pipeline register and selects load data or ALU result for the register-file write port. It retires instructions, counts them, and detects a halt instruction, freezing architectural writes afterwards. It also drives the WB-stage instruction type/number used by the pipeline monitor display.

Parameters:
HALT_TYPE, 4'hF, ins_type code of the halt instruction
NOP_TYPE, 4'h0, ins_type code of a bubble/NOP (not counted as retired)
LOAD_TYPE, 4'h3, ins_type code of a load (used by the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mem_valid  in  1  MEM-stage contents are valid; 0 = latch a bubble
mem_wreg  in  1  register write enable from MEM
mem_m2reg  in  1  1 = write back load data, 0 = ALU result
mem_mdata  in  32  data memory read data
mem_aluR  in  32  ALU result carried through MEM
mem_destR  in  5  destination register number
MEM_ins_type  in  4  instruction type in MEM
MEM_ins_number  in  4  instruction number in MEM
wb_wreg  out  1  register-file write enable
wb_destR  out  5  register-file write address
wb_data  out  32  register-file write data
WB_ins_type  out  4  instruction type in WB
WB_ins_number  out  4  instruction number in WB
halted  out  1  CPU halted
retire_count  out  32  retired instructions
load_count  out  16  retired loads (optional feature)

Behaviour:
- One clock and one reset. The reset is synchronous and active-high: on the clk edge with rst=1 all state clears. Ports are named clk and rst.
- Reset values: wb_wreg=0, wb_destR=0, wb_data=0, WB_ins_type=NOP_TYPE, WB_ins_number=0, halted=0, retire_count=0, load_count=0. The FSM enters RUN.
- MEM/WB register: 1-cycle latency.
  - On each edge in RUN with mem_valid=1, it latches wreg, m2reg, mdata, aluR, destR, ins_type and ins_number.
  - With mem_valid=0, it latches a bubble: wreg=0, destR=0, type=NOP_TYPE, number=0. Data fields are don't-care and are held.
- wb_data is combinational from the register: m2reg ? latched mdata : latched aluR.
- wb_wreg = latched wreg & (latched destR != 0) & ~halted. Writes to r0 are always suppressed.
- FSM states:
  - RUN -> HALTED when the WB register holds WB_ins_type==HALT_TYPE. The transition takes effect on the next edge, and halted=1 from that edge on.
  - HALTED: the MEM/WB register stops loading and the outputs hold their last values, except that wb_wreg is forced to 0. Counters freeze. The only exit is rst.
- The halt instruction itself is counted. Its wreg is ignored: the halt type never writes.
- retire_count increments by 1 on each edge in RUN where the WB register holds a type other than NOP_TYPE. It saturates at 32'hFFFFFFFF and does not wrap.
- Simultaneous events:
  - rst has priority over everything, including a halt arriving in the same cycle.
  - A halt in WB while a new instruction arrives from MEM: that instruction is still latched on the same edge, because HALTED is not yet active. It is then frozen and never written, since wb_wreg is forced to 0.
- rst asserted mid-stream discards the in-flight WB instruction; no write occurs on that edge.

Optional Feature:
- Macro WB_LOAD_COUNT_EN.
- Defined: load_count increments, saturating at 16'hFFFF, on each RUN edge where WB_ins_type==LOAD_TYPE. It clears on rst and freezes in HALTED.
- Undefined: load_count is tied to 16'h0000 and the counter logic is not built.

Decomposition:
- Shared package/header (cpu_defs): ins_type codes (NOP, LOAD, HALT, ...), data width 32 and register-address width 5. The same constants are used by the exe/mem stages and the monitor.
- One natural sub-module, Reg_MEM_WB: the pipeline register with load-enable and bubble insert.
- The FSM, the write-back mux and the counters live in wb_stage.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs at reset values and halted=0.
2. ALU write-back: mem_valid=1, wreg=1, m2reg=0, aluR=32'h0000_1234, destR=5 -> next cycle wb_wreg=1, wb_destR=5, wb_data=32'h1234, retire_count=1 one edge later.
3. Load write-back and r0 guard: m2reg=1, mdata=32'hDEAD_BEEF, destR=7 -> wb_data=DEADBEEF and wb_wreg=1. The same with destR=0 gives wb_wreg=0, while retire_count still increments.
4. Bubbles: mem_valid=0 for 3 cycles -> WB_ins_type=NOP_TYPE, wb_wreg=0, retire_count unchanged.
5. Halt: halt type, then an ALU op to destR=9 -> halted=1 one edge after the halt reaches WB, wb_wreg stays 0 and the count freezes. A later rst pulse restores RUN with count 0.
6. Saturation and option: force retire_count near 32'hFFFFFFFE and retire 3 instructions -> holds at FFFFFFFF. With WB_LOAD_COUNT_EN, 4 loads give load_count=4; without the macro, load_count stays 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// CPU-wide constants shared by the exe/mem/wb stages and the pipeline monitor:
// datapath widths, instruction-type codes and the MEM/WB register layout.
package wb_stage_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int TYPE_W = 4;
   localparam int NUM_W  = 4;

   localparam logic [TYPE_W-1:0] INS_NOP   = 4'h0;
   localparam logic [TYPE_W-1:0] INS_ALU   = 4'h1;
   localparam logic [TYPE_W-1:0] INS_STORE = 4'h2;
   localparam logic [TYPE_W-1:0] INS_LOAD  = 4'h3;
   localparam logic [TYPE_W-1:0] INS_HALT  = 4'hF;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic              wreg;
      logic              m2reg;
      logic [XLEN-1:0]   mdata;
      logic [XLEN-1:0]   aluR;
      logic [REG_AW-1:0] destR;
      logic [TYPE_W-1:0] ins_type;
      logic [NUM_W-1:0]  ins_number;
   } mem_wb_t;

endpackage

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register: loads when enabled, inserts a bubble when MEM is
// not valid (control fields cleared, data fields held).
module Reg_MEM_WB
   import wb_stage_pkg::*;
#(
   parameter logic [TYPE_W-1:0] NOP_TYPE = INS_NOP
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    load_en_i,
   input  logic    valid_i,
   input  mem_wb_t d_i,
   output mem_wb_t q_o
);

   mem_wb_t q_q;
   mem_wb_t q_d;

   always_comb begin
      q_d = q_q;
      if (load_en_i) begin
         if (valid_i) begin
            q_d = d_i;
         end else begin
            q_d.wreg       = 1'b0;
            q_d.destR      = '0;
            q_d.ins_type   = NOP_TYPE;
            q_d.ins_number = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q.wreg       <= 1'b0;
         q_q.m2reg      <= 1'b0;
         q_q.mdata      <= '0;
         q_q.aluR       <= '0;
         q_q.destR      <= '0;
         q_q.ins_type   <= NOP_TYPE;
         q_q.ins_number <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, write-back mux, halt FSM, retire counters.
// Optional retired-load counter is built when WB_LOAD_COUNT_EN is defined.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [TYPE_W-1:0] HALT_TYPE = INS_HALT,
   parameter logic [TYPE_W-1:0] NOP_TYPE  = INS_NOP,
   parameter logic [TYPE_W-1:0] LOAD_TYPE = INS_LOAD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [XLEN-1:0]   mem_mdata,
   input  logic [XLEN-1:0]   mem_aluR,
   input  logic [REG_AW-1:0] mem_destR,
   input  logic [TYPE_W-1:0] MEM_ins_type,
   input  logic [NUM_W-1:0]  MEM_ins_number,
   output logic              wb_wreg,
   output logic [REG_AW-1:0] wb_destR,
   output logic [XLEN-1:0]   wb_data,
   output logic [TYPE_W-1:0] WB_ins_type,
   output logic [NUM_W-1:0]  WB_ins_number,
   output logic              halted,
   output logic [31:0]       retire_count,
   output logic [15:0]       load_count
);

   wb_state_e state_q, state_d;
   logic      run;
   mem_wb_t   mem_in;
   mem_wb_t   wb_q;
   logic [31:0] retire_count_q, retire_count_d;

   assign mem_in = '{wreg: mem_wreg, m2reg: mem_m2reg, mdata: mem_mdata,
                     aluR: mem_aluR, destR: mem_destR,
                     ins_type: MEM_ins_type, ins_number: MEM_ins_number};

   Reg_MEM_WB #(.NOP_TYPE(NOP_TYPE)) u_reg_mem_wb (
      .clk       (clk),
      .rst       (rst),
      .load_en_i (run),
      .valid_i   (mem_valid),
      .d_i       (mem_in),
      .q_o       (wb_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (wb_q.ins_type == HALT_TYPE) state_d = ST_HALTED;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_comb begin
      run    = (state_q == ST_RUN);
      halted = (state_q == ST_HALTED);
   end

   // The halt instruction itself never writes, even if it carries wreg=1.
   assign wb_wreg = wb_q.wreg & (wb_q.destR != '0) & ~halted &
                    (wb_q.ins_type != HALT_TYPE);
   assign wb_destR      = wb_q.destR;
   assign wb_data       = wb_q.m2reg ? wb_q.mdata : wb_q.aluR;
   assign WB_ins_type   = wb_q.ins_type;
   assign WB_ins_number = wb_q.ins_number;

   always_comb begin
      retire_count_d = retire_count_q;
      if (run && (wb_q.ins_type != NOP_TYPE) && (retire_count_q != 32'hFFFF_FFFF))
         retire_count_d = retire_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) retire_count_q <= '0;
      else     retire_count_q <= retire_count_d;
   end

   assign retire_count = retire_count_q;

`ifdef WB_LOAD_COUNT_EN
   logic [15:0] load_count_q, load_count_d;

   always_comb begin
      load_count_d = load_count_q;
      if (run && (wb_q.ins_type == LOAD_TYPE) && (load_count_q != 16'hFFFF))
         load_count_d = load_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) load_count_q <= '0;
      else     load_count_q <= load_count_d;
   end

   assign load_count = load_count_q;
`else
   logic unused_load_type;
   assign unused_load_type = ^LOAD_TYPE;
   assign load_count = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the main stream plus
// hand-written reset, saturation and halt/reset-priority sequences.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_wreg, mem_m2reg;
   logic [31:0] mem_mdata, mem_aluR;
   logic [4:0]  mem_destR;
   logic [3:0]  MEM_ins_type, MEM_ins_number;
   logic        wb_wreg;
   logic [4:0]  wb_destR;
   logic [31:0] wb_data;
   logic [3:0]  WB_ins_type, WB_ins_number;
   logic        halted;
   logic [31:0] retire_count;
   logic [15:0] load_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wreg(mem_wreg),
      .mem_m2reg(mem_m2reg), .mem_mdata(mem_mdata), .mem_aluR(mem_aluR),
      .mem_destR(mem_destR), .MEM_ins_type(MEM_ins_type),
      .MEM_ins_number(MEM_ins_number), .wb_wreg(wb_wreg), .wb_destR(wb_destR),
      .wb_data(wb_data), .WB_ins_type(WB_ins_type), .WB_ins_number(WB_ins_number),
      .halted(halted), .retire_count(retire_count), .load_count(load_count)
   );

   typedef struct {
      logic        valid, wreg, m2reg;
      logic [31:0] mdata, aluR;
      logic [4:0]  destR;
      logic [3:0]  itype, inum;
      logic        e_wreg;
      logic [4:0]  e_destR;
      logic [31:0] e_data;
      logic [3:0]  e_type, e_num;
      logic        e_halted;
      logic [31:0] e_rc;
      logic [15:0] e_lc;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic m2, input logic [31:0] md,
                        input logic [31:0] al, input logic [4:0] d, input logic [3:0] t,
                        input logic [3:0] n);
      mem_valid = v; mem_wreg = w; mem_m2reg = m2; mem_mdata = md; mem_aluR = al;
      mem_destR = d; MEM_ins_type = t; MEM_ins_number = n;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] lc_exp(input logic [15:0] v);
`ifdef WB_LOAD_COUNT_EN
      return v;
`else
      return 16'h0000 & v;
`endif
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_wreg"}, 32'(wb_wreg), 32'd0);
      check({tag, "_destR"}, 32'(wb_destR), 32'd0);
      check({tag, "_data"}, wb_data, 32'd0);
      check({tag, "_type"}, 32'(WB_ins_type), 32'h0);
      check({tag, "_num"}, 32'(WB_ins_number), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_rc"}, retire_count, 32'd0);
      check({tag, "_lc"}, 32'(load_count), 32'd0);
   endtask

   initial begin
      //        v  w  m2 mdata          aluR          dest typ num | wreg dest data         typ  num h  rc   lc
      vecs[0]  = '{1,1,0,32'h0,          32'h0000_1234,5, 4'h1,4'h1, 1,5, 32'h0000_1234,4'h1,4'h1,0,32'd0,16'd0};
      vecs[1]  = '{1,1,1,32'hDEAD_BEEF,  32'h0,        7, 4'h3,4'h2, 1,7, 32'hDEAD_BEEF,4'h3,4'h2,0,32'd1,16'd0};
      vecs[2]  = '{1,1,1,32'hCAFE_F00D,  32'h0,        0, 4'h3,4'h3, 0,0, 32'hCAFE_F00D,4'h3,4'h3,0,32'd2,16'd1};
      vecs[3]  = '{0,1,0,32'h1111_1111,  32'h2222_2222,6, 4'h1,4'h9, 0,0, 32'hCAFE_F00D,4'h0,4'h0,0,32'd3,16'd2};
      vecs[4]  = '{0,1,1,32'h3333_3333,  32'h4444_4444,8, 4'h3,4'hA, 0,0, 32'hCAFE_F00D,4'h0,4'h0,0,32'd3,16'd2};
      vecs[5]  = '{0,0,0,32'h5555_5555,  32'h6666_6666,2, 4'h2,4'hB, 0,0, 32'hCAFE_F00D,4'h0,4'h0,0,32'd3,16'd2};
      vecs[6]  = '{1,0,0,32'h0,          32'h0000_0055,4, 4'h2,4'h4, 0,4, 32'h0000_0055,4'h2,4'h4,0,32'd3,16'd2};
      vecs[7]  = '{1,1,0,32'h0,          32'h0000_AAAA,31,4'h1,4'h5, 1,31,32'h0000_AAAA,4'h1,4'h5,0,32'd4,16'd2};
      vecs[8]  = '{1,1,0,32'h0,          32'h0000_0000,3, 4'hF,4'h6, 0,3, 32'h0000_0000,4'hF,4'h6,0,32'd5,16'd2};
      vecs[9]  = '{1,1,0,32'h0,          32'h0000_0099,9, 4'h1,4'h7, 0,9, 32'h0000_0099,4'h1,4'h7,1,32'd6,16'd2};
      vecs[10] = '{1,1,0,32'h0,          32'h0000_0077,10,4'h1,4'h8, 0,9, 32'h0000_0099,4'h1,4'h7,1,32'd6,16'd2};
      vecs[11] = '{1,1,1,32'h0BAD_0BAD,  32'h0,        11,4'h3,4'h9, 0,9, 32'h0000_0099,4'h1,4'h7,1,32'd6,16'd2};

      // Reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
               5'($urandom_range(1, 31)), 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
         step();
      end
      check_reset_state("reset");
      rst = 1'b0;

      // Main stream: ALU, loads, r0 guard, bubbles, halt and freeze
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].valid, vecs[i].wreg, vecs[i].m2reg, vecs[i].mdata, vecs[i].aluR,
               vecs[i].destR, vecs[i].itype, vecs[i].inum);
         step();
         check($sformatf("v%0d_wreg", i), 32'(wb_wreg), 32'(vecs[i].e_wreg));
         check($sformatf("v%0d_destR", i), 32'(wb_destR), 32'(vecs[i].e_destR));
         check($sformatf("v%0d_data", i), wb_data, vecs[i].e_data);
         check($sformatf("v%0d_type", i), 32'(WB_ins_type), 32'(vecs[i].e_type));
         check($sformatf("v%0d_num", i), 32'(WB_ins_number), 32'(vecs[i].e_num));
         check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
         check($sformatf("v%0d_rc", i), retire_count, vecs[i].e_rc);
         check($sformatf("v%0d_lc", i), 32'(load_count), 32'(lc_exp(vecs[i].e_lc)));
      end

      // Reset pulse out of HALTED
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'h0, 4'h0);
      step();
      check_reset_state("rst_from_halt");
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0042, 5'd12, 4'h1, 4'h1);
      step();
      check("rerun_wreg", 32'(wb_wreg), 32'd1);
      check("rerun_data", wb_data, 32'h0000_0042);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'h0, 4'h0);
      step();
      check("rerun_rc", retire_count, 32'd1);

      // Saturation: preload the counter while WB holds a bubble, then retire 4 loads
      force dut.retire_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.retire_count_q;
      step();
      check("sat_preload", retire_count, 32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i), 32'h0, 5'd1, 4'h3, 4'(i));
         step();
         if (i == 2) check("sat_rc_ff", retire_count, 32'hFFFF_FFFF);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'h0, 4'h0);
      step();
      check("sat_rc_hold", retire_count, 32'hFFFF_FFFF);
      check("load_count_4", 32'(load_count), 32'(lc_exp(16'd4)));

      // Reset wins over a halt sitting in WB
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'hF, 4'h5);
      step();
      check("halt_in_wb_not_yet", 32'(halted), 32'd0);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0123, 5'd6, 4'h1, 4'h6);
      step();
      check("rst_prio_halted", 32'(halted), 32'd0);
      check("rst_prio_type", 32'(WB_ins_type), 32'h0);
      check("rst_prio_wreg", 32'(wb_wreg), 32'd0);
      check("rst_prio_rc", retire_count, 32'd0);
      rst = 1'b0;
      step();
      check("after_rst_run", 32'(halted), 32'd0);
      check("after_rst_wreg", 32'(wb_wreg), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
